lcd_cmd_sequencer: RTL and testbench
====================================

Name: lcd_cmd_sequencer

Overview:
Sequencer that drives the ST7735R byte serializer, so software does not have to poke CSR/DATA once per byte.
- Runs a hard-coded power-up init script from a ROM: commands, parameters and ms delays.
- Programs an address window with CASET/RASET/RAMWR.
- Streams RGB565 pixels from a valid/ready source as hi/lo byte pairs.
- Owns the serializer's data_load/data, the dcx line and the LCD reset pin.
- Sits between the Wishbone LCD register block or a pixel DMA and the serializer.

Parameters:
RST_LOW_CYCLES, 1000, clocks lcd_rst is held low during init.
DELAY_UNIT_CYCLES, 96000, clocks per ROM delay unit (1 ms at 96 MHz).
ROM_AW, 6, init ROM address width (64 entries).

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
init_start  in  1  pulse: run reset + init script
abort  in  1  pulse: stop after current byte, go IDLE
win_valid  in  1  window request valid
win_ready  out  1  high only in IDLE with init_ok=1
win_x0, win_x1, win_y0, win_y1  in  8 each  inclusive window corners
pix_valid  in  1  pixel available
pix_ready  out  1  pixel accepted this cycle (valid&ready)
pix_data  in  16  RGB565 pixel
busy  out  1  not IDLE
init_ok  out  1  init script completed since reset
err  out  1  sticky: bad window (x1<x0 or y1<y0); cleared by next accepted window
byte_load  out  1  single-cycle load strobe to serializer
byte_data  out  8  byte to serializer, stable from load until done
dcx  out  1  0=command, 1=data; stable from load until done
lcd_rst  out  1  LCD reset pin, active-low
byte_done  in  1  serializer completion pulse

Behaviour:
- Reset values: lcd_rst=1, dcx=0, byte_load=0, byte_data=0, busy=0, init_ok=0, err=0, win_ready=0, pix_ready=0. State=IDLE, all counters 0.
- Byte handshake:
  - SEND state asserts byte_load for exactly 1 cycle with byte_data/dcx valid that same cycle.
  - WAIT state ignores byte_done in the load cycle.
  - The first byte_done=1 in a later cycle completes the byte; the next byte_load comes no earlier than the following cycle.
  - Minimum 2 cycles between consecutive loads.
- ROM entry, 10 bits {type[1:0], payload[7:0]}:
  - 00 = command (dcx=0).
  - 01 = data (dcx=1).
  - 10 = delay of payload × DELAY_UNIT_CYCLES; payload 0 means no delay.
  - 11 = end.
- ROM is synchronous, 1-cycle read latency.
- State machine:
  - IDLE: init_start → RST_LO.
    - If init_ok=1: win_valid&win_ready → WIN, which latches the corners.
    - Bad corners: err=1, stay IDLE; the request is still consumed (win_ready was high).
    - init_start has priority over win_valid in the same cycle.
  - RST_LO: lcd_rst=0 for RST_LOW_CYCLES, then lcd_rst=1 → RST_WAIT.
  - RST_WAIT: wait DELAY_UNIT_CYCLES → ROM_FETCH with addr=0.
  - ROM_FETCH: read entry, then dispatch:
    - cmd/data → SEND;
    - delay → DLY;
    - end → IDLE with init_ok=1;
    - addr wrap past 2^ROM_AW-1 is treated as end.
  - SEND/WAIT (shared): after done, return to the caller: ROM_FETCH (addr+1), WIN (index+1) or PIX.
  - DLY: count payload×DELAY_UNIT_CYCLES → ROM_FETCH (addr+1).
  - WIN: 11 bytes in order:
    - 0x2A cmd, 0x00, x0, 0x00, x1;
    - 0x2B cmd, 0x00, y0, 0x00, y1;
    - 0x2C cmd.
    - Then load pixel count = (x1-x0+1)*(y1-y0+1), 17 bits, max 65536, → PIX.
  - PIX:
    - pix_ready=1 for one cycle when waiting for a pixel; on valid&ready capture pix_data.
    - Send hi byte, then lo byte, both dcx=1; decrement count after lo completes.
    - count=0 → IDLE.
    - No pixel available: stall indefinitely; pix_ready stays high until accepted.
- Abort:
  - Sampled in any non-IDLE state and latched.
  - Takes effect at the next byte boundary (after done) or immediately in RST_LO/RST_WAIT/DLY/PIX-wait.
  - Abort during init leaves init_ok=0; abort during RST_LO releases lcd_rst=1.
- init_start while busy: ignored.
- Asynchronous reset mid-transfer returns to reset values; the serializer is reset by the same reset_n.

Decomposition:
- Package lcd_pkg: entry type enum (LCD_ENT_CMD/DATA/DELAY/END), state enum, ST7735 opcodes (CASET 0x2A, RASET 0x2B, RAMWR 0x2C, SWRESET 0x01, SLPOUT 0x11, COLMOD 0x3A, DISPON 0x29).
- Sub-module lcd_init_rom: synchronous case-ROM, addr[ROM_AW-1:0] → entry[9:0].
- Bench uses short parameters: RST_LOW_CYCLES=8, DELAY_UNIT_CYCLES=4.

Test Plan:
- Init run:
  - Stimulus: init_start pulse; ROM script {cmd 0x01, delay 2, cmd 0x11, cmd 0x3A, data 0x05, cmd 0x29, end}.
  - Required: lcd_rst low exactly 8 cycles; bytes 01(dcx0) 11(dcx0) 3A(dcx0) 05(dcx1) 29(dcx0); gap ≥8 cycles after 0x01; init_ok=1, busy=0.
- Window:
  - Stimulus: x0=2, x1=5, y0=10, y1=11.
  - Required: bytes 2A,00,02,00,05,2B,00,0A,00,0B,2C with dcx pattern 0,1,1,1,1,0,1,1,1,1,0; then exactly 8 pixels consumed.
- Pixel stream with gaps:
  - Stimulus: pixels 0xF800, 0x07E0 with pix_valid dropped 5 cycles between them.
  - Required: bytes F8,00,07,E0, all dcx=1; no load issued during the gap.
- Bad window:
  - Stimulus: x0=9, x1=3.
  - Required: err=1, no byte_load, stays IDLE.
  - Follow-up: a good window clears err.
- Abort mid-stream:
  - Stimulus: 1×1… 4×4 window, abort during pixel 3 hi byte.
  - Required: that byte completes, no further loads, IDLE next cycle after done.
- Gating and reset:
  - Stimulus: window request before init, then async reset during a WAIT.
  - Required: win_ready=0 before init; all outputs return to reset values immediately; byte_done after reset ignored.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types, ST7735R opcodes and the window byte table
// used by the LCD command sequencer and its init ROM.
package lcd_pkg;

    // Init ROM entry type, upper two bits of each 10-bit entry.
    typedef enum logic [1:0] {
        LCD_ENT_CMD   = 2'b00,
        LCD_ENT_DATA  = 2'b01,
        LCD_ENT_DELAY = 2'b10,
        LCD_ENT_END   = 2'b11
    } lcd_ent_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST_LO,
        S_RST_WAIT,
        S_ROM_FETCH,
        S_ROM_DISP,
        S_DLY,
        S_SEND,
        S_WAIT,
        S_WIN,
        S_PIX
    } lcd_state_e;

    // Where SEND/WAIT returns once the serializer finishes a byte.
    typedef enum logic [1:0] {
        RET_ROM,
        RET_WIN,
        RET_HI,
        RET_LO
    } lcd_ret_e;

    localparam logic [7:0] ST_SWRESET = 8'h01;
    localparam logic [7:0] ST_SLPOUT  = 8'h11;
    localparam logic [7:0] ST_COLMOD  = 8'h3A;
    localparam logic [7:0] ST_DISPON  = 8'h29;
    localparam logic [7:0] ST_CASET   = 8'h2A;
    localparam logic [7:0] ST_RASET   = 8'h2B;
    localparam logic [7:0] ST_RAMWR   = 8'h2C;

    localparam logic [3:0] WIN_BYTES = 4'd11;

    // Window programming byte idx as {dcx, byte}.
    function automatic logic [8:0] win_byte(
        input logic [3:0] idx,
        input logic [7:0] x0,
        input logic [7:0] x1,
        input logic [7:0] y0,
        input logic [7:0] y1
    );
        logic [8:0] r;
        case (idx)
            4'd0:    r = {1'b0, ST_CASET};
            4'd1:    r = {1'b1, 8'h00};
            4'd2:    r = {1'b1, x0};
            4'd3:    r = {1'b1, 8'h00};
            4'd4:    r = {1'b1, x1};
            4'd5:    r = {1'b0, ST_RASET};
            4'd6:    r = {1'b1, 8'h00};
            4'd7:    r = {1'b1, y0};
            4'd8:    r = {1'b1, 8'h00};
            4'd9:    r = {1'b1, y1};
            default: r = {1'b0, ST_RAMWR};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// lcd_init_rom: power-up script for the ST7735R, synchronous read.
// Ports: clk, reset_n, addr in; entry {type[1:0], payload[7:0]} out.
module lcd_init_rom
    import lcd_pkg::*;
#(
    parameter int ROM_AW = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ROM_AW-1:0] addr,
    output logic [9:0]        entry
);

    logic [9:0] rd;

    always_comb begin
        rd = {LCD_ENT_END, 8'h00};
        case (int'(addr))
            0:       rd = {LCD_ENT_CMD, ST_SWRESET};
            1:       rd = {LCD_ENT_DELAY, 8'd2};
            2:       rd = {LCD_ENT_CMD, ST_SLPOUT};
            3:       rd = {LCD_ENT_CMD, ST_COLMOD};
            4:       rd = {LCD_ENT_DATA, 8'h05};
            5:       rd = {LCD_ENT_CMD, ST_DISPON};
            default: rd = {LCD_ENT_END, 8'h00};
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) entry <= '0;
        else          entry <= rd;
    end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer: runs LCD reset + init ROM, programs CASET/RASET/
// RAMWR windows and streams RGB565 pixels into the byte serializer.
// Ports: init_start/abort control; win_* window request (valid/ready);
// pix_* pixel stream (valid/ready); busy/init_ok/err status;
// byte_load/byte_data/dcx/byte_done serializer link; lcd_rst pin.
module lcd_cmd_sequencer
    import lcd_pkg::*;
#(
    parameter int RST_LOW_CYCLES    = 1000,
    parameter int DELAY_UNIT_CYCLES = 96000,
    parameter int ROM_AW            = 6
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        init_start,
    input  logic        abort,
    input  logic        win_valid,
    output logic        win_ready,
    input  logic [7:0]  win_x0,
    input  logic [7:0]  win_x1,
    input  logic [7:0]  win_y0,
    input  logic [7:0]  win_y1,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [15:0] pix_data,
    output logic        busy,
    output logic        init_ok,
    output logic        err,
    output logic        byte_load,
    output logic [7:0]  byte_data,
    output logic        dcx,
    output logic        lcd_rst,
    input  logic        byte_done
);

    localparam logic [31:0] RST_LAST = 32'(RST_LOW_CYCLES - 1);
    localparam logic [31:0] DLY_LAST = 32'(DELAY_UNIT_CYCLES - 1);

    lcd_state_e        state_q, state_d;
    lcd_ret_e          ret_q, ret_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [7:0]        units_q, units_d;
    logic [ROM_AW-1:0] addr_q, addr_d;
    logic [3:0]        idx_q, idx_d;
    logic [7:0]        x0_q, x0_d, x1_q, x1_d;
    logic [7:0]        y0_q, y0_d, y1_q, y1_d;
    logic [16:0]       pcnt_q, pcnt_d;
    logic [15:0]       pix_q, pix_d;
    logic              init_ok_q, init_ok_d;
    logic              err_q, err_d;
    logic              rst_q, rst_d;
    logic [7:0]        byte_q, byte_d;
    logic              dcx_q, dcx_d;
    logic              abort_q, abort_d;

    logic [9:0]        rom_entry;
    logic [8:0]        wb;
    logic [8:0]        w, h;
    logic              ab;
    logic              rom_adv;

    lcd_init_rom #(
        .ROM_AW (ROM_AW)
    ) u_rom (
        .clk     (clk),
        .reset_n (reset_n),
        .addr    (addr_q),
        .entry   (rom_entry)
    );

    assign wb = win_byte(idx_q, x0_q, x1_q, y0_q, y1_q);
    assign w  = {1'b0, x1_q} - {1'b0, x0_q} + 9'd1;
    assign h  = {1'b0, y1_q} - {1'b0, y0_q} + 9'd1;
    assign ab = abort_q | abort;

    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        cnt_d     = cnt_q;
        units_d   = units_q;
        addr_d    = addr_q;
        idx_d     = idx_q;
        x0_d      = x0_q;
        x1_d      = x1_q;
        y0_d      = y0_q;
        y1_d      = y1_q;
        pcnt_d    = pcnt_q;
        pix_d     = pix_q;
        init_ok_d = init_ok_q;
        err_d     = err_q;
        rst_d     = rst_q;
        byte_d    = byte_q;
        dcx_d     = dcx_q;
        abort_d   = abort_q | (abort & (state_q != S_IDLE));
        rom_adv   = 1'b0;
        win_ready = (state_q == S_IDLE) & init_ok_q & ~init_start;
        pix_ready = 1'b0;
        byte_load = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (init_start) begin
                    state_d   = S_RST_LO;
                    rst_d     = 1'b0;
                    cnt_d     = '0;
                    init_ok_d = 1'b0;
                end else if (win_valid && win_ready) begin
                    if (win_x1 < win_x0 || win_y1 < win_y0) begin
                        err_d = 1'b1;
                    end else begin
                        err_d   = 1'b0;
                        x0_d    = win_x0;
                        x1_d    = win_x1;
                        y0_d    = win_y0;
                        y1_d    = win_y1;
                        idx_d   = '0;
                        state_d = S_WIN;
                    end
                end
            end
            S_RST_LO: begin
                if (ab) begin
                    rst_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_q == RST_LAST) begin
                    rst_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_RST_WAIT;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_RST_WAIT: begin
                if (ab) begin
                    state_d = S_IDLE;
                end else if (cnt_q == DLY_LAST) begin
                    cnt_d   = '0;
                    addr_d  = '0;
                    state_d = S_ROM_FETCH;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_ROM_FETCH: begin
                state_d = ab ? S_IDLE : S_ROM_DISP;
            end
            S_ROM_DISP: begin
                if (ab) begin
                    state_d = S_IDLE;
                end else begin
                    case (lcd_ent_e'(rom_entry[9:8]))
                        LCD_ENT_CMD, LCD_ENT_DATA: begin
                            byte_d  = rom_entry[7:0];
                            dcx_d   = rom_entry[8];
                            ret_d   = RET_ROM;
                            state_d = S_SEND;
                        end
                        LCD_ENT_DELAY: begin
                            if (rom_entry[7:0] == 8'd0) begin
                                rom_adv = 1'b1;
                            end else begin
                                units_d = rom_entry[7:0];
                                cnt_d   = '0;
                                state_d = S_DLY;
                            end
                        end
                        default: begin
                            init_ok_d = 1'b1;
                            state_d   = S_IDLE;
                        end
                    endcase
                end
            end
            S_DLY: begin
                if (ab) begin
                    state_d = S_IDLE;
                end else if (cnt_q == DLY_LAST) begin
                    cnt_d = '0;
                    if (units_q == 8'd1) rom_adv = 1'b1;
                    else                 units_d = units_q - 8'd1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_SEND: begin
                byte_load = 1'b1;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                // Entered only after the load cycle, so a done
                // coinciding with the load is never seen here.
                if (byte_done) begin
                    if (ab) begin
                        state_d = S_IDLE;
                    end else begin
                        unique case (ret_q)
                            RET_ROM: rom_adv = 1'b1;
                            RET_WIN: begin
                                idx_d   = idx_q + 4'd1;
                                state_d = S_WIN;
                            end
                            RET_HI: begin
                                byte_d  = pix_q[7:0];
                                dcx_d   = 1'b1;
                                ret_d   = RET_LO;
                                state_d = S_SEND;
                            end
                            RET_LO: begin
                                pcnt_d  = pcnt_q - 17'd1;
                                state_d = S_PIX;
                            end
                        endcase
                    end
                end
            end
            S_WIN: begin
                if (ab) begin
                    state_d = S_IDLE;
                end else if (idx_q == WIN_BYTES) begin
                    pcnt_d  = 17'(w) * 17'(h);
                    state_d = S_PIX;
                end else begin
                    dcx_d   = wb[8];
                    byte_d  = wb[7:0];
                    ret_d   = RET_WIN;
                    state_d = S_SEND;
                end
            end
            S_PIX: begin
                if (pcnt_q == 17'd0 || ab) begin
                    state_d = S_IDLE;
                end else begin
                    pix_ready = 1'b1;
                    if (pix_valid) begin
                        pix_d   = pix_data;
                        byte_d  = pix_data[15:8];
                        dcx_d   = 1'b1;
                        ret_d   = RET_HI;
                        state_d = S_SEND;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Step to the next ROM entry; running off the top ends init.
        if (rom_adv) begin
            if (&addr_q) begin
                init_ok_d = 1'b1;
                state_d   = S_IDLE;
            end else begin
                addr_d  = addr_q + 1'b1;
                state_d = S_ROM_FETCH;
            end
        end

        if (state_d == S_IDLE) abort_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            ret_q     <= RET_ROM;
            cnt_q     <= '0;
            units_q   <= '0;
            addr_q    <= '0;
            idx_q     <= '0;
            x0_q      <= '0;
            x1_q      <= '0;
            y0_q      <= '0;
            y1_q      <= '0;
            pcnt_q    <= '0;
            pix_q     <= '0;
            init_ok_q <= 1'b0;
            err_q     <= 1'b0;
            rst_q     <= 1'b1;
            byte_q    <= '0;
            dcx_q     <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            cnt_q     <= cnt_d;
            units_q   <= units_d;
            addr_q    <= addr_d;
            idx_q     <= idx_d;
            x0_q      <= x0_d;
            x1_q      <= x1_d;
            y0_q      <= y0_d;
            y1_q      <= y1_d;
            pcnt_q    <= pcnt_d;
            pix_q     <= pix_d;
            init_ok_q <= init_ok_d;
            err_q     <= err_d;
            rst_q     <= rst_d;
            byte_q    <= byte_d;
            dcx_q     <= dcx_d;
            abort_q   <= abort_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign init_ok   = init_ok_q;
    assign err       = err_q;
    assign byte_data = byte_q;
    assign dcx       = dcx_q;
    assign lcd_rst   = rst_q;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// tb_lcd_cmd_sequencer: scoreboard bench with a serializer model
// that checks every loaded byte against the expected stream.
module tb_lcd_cmd_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        init_start = 1'b0;
    logic        abort = 1'b0;
    logic        win_valid = 1'b0;
    logic [7:0]  win_x0 = '0;
    logic [7:0]  win_x1 = '0;
    logic [7:0]  win_y0 = '0;
    logic [7:0]  win_y1 = '0;
    logic        pix_valid = 1'b0;
    logic [15:0] pix_data = '0;
    logic        byte_done = 1'b0;
    logic        win_ready, pix_ready, busy, init_ok, err;
    logic        byte_load, dcx, lcd_rst;
    logic [7:0]  byte_data;

    lcd_cmd_sequencer #(
        .RST_LOW_CYCLES    (8),
        .DELAY_UNIT_CYCLES (4),
        .ROM_AW            (6)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .init_start (init_start),
        .abort      (abort),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_x0     (win_x0),
        .win_x1     (win_x1),
        .win_y0     (win_y0),
        .win_y1     (win_y1),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .busy       (busy),
        .init_ok    (init_ok),
        .err        (err),
        .byte_load  (byte_load),
        .byte_data  (byte_data),
        .dcx        (dcx),
        .lcd_rst    (lcd_rst),
        .byte_done  (byte_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_loads = 0;
    int n_pix = 0;
    int last_load = -100;
    int t01 = 0;
    int gap01 = 0;
    int done_cyc = 0;
    int rst_run = 0;
    int rst_len = 0;
    int lat_force = 0;
    bit skip_hold = 1'b0;
    logic [8:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] outs();
        return {lcd_rst, dcx, byte_load, byte_data,
                busy, init_ok, err, win_ready, pix_ready};
    endfunction

    initial forever @(posedge clk) cyc++;

    initial forever begin
        @(negedge clk);
        #1;
        if (pix_valid && pix_ready) n_pix++;
    end

    initial forever begin
        @(negedge clk);
        if (!lcd_rst) begin
            rst_run++;
        end else if (rst_run != 0) begin
            rst_len = rst_run;
            rst_run = 0;
        end
    end

    // Serializer model: pops/compares each load, raises a stray done
    // in the load cycle, then a real done after a few cycles.
    initial begin
        logic [8:0] got;
        logic [8:0] e;
        int lat;
        @(negedge clk);
        forever begin
            if (reset_n && byte_load) begin
                got = {dcx, byte_data};
                n_loads++;
                chk("load_gap", 32'(cyc - last_load >= 2), 32'd1);
                last_load = cyc;
                if (got == 9'h001) t01 = cyc;
                if (got == 9'h011) gap01 = cyc - t01;
                if (exp_q.size() == 0) begin
                    chk("extra_load", 32'(got), 32'h200);
                end else begin
                    e = exp_q.pop_front();
                    chk("byte", 32'(got), 32'(e));
                end
                byte_done = 1'b1;
                @(negedge clk);
                byte_done = 1'b0;
                lat = (lat_force != 0) ? lat_force : 1 + (n_loads % 3);
                repeat (lat) @(negedge clk);
                if (!skip_hold)
                    chk("hold", 32'({dcx, byte_data}), 32'(got));
                byte_done = 1'b1;
                done_cyc = cyc;
                @(negedge clk);
                byte_done = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    end

    task automatic push_b(input logic d, input logic [7:0] b);
        exp_q.push_back({d, b});
    endtask

    task automatic push_win(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
        push_b(1'b0, 8'h2A);
        push_b(1'b1, 8'h00);
        push_b(1'b1, a);
        push_b(1'b1, 8'h00);
        push_b(1'b1, b);
        push_b(1'b0, 8'h2B);
        push_b(1'b1, 8'h00);
        push_b(1'b1, c);
        push_b(1'b1, 8'h00);
        push_b(1'b1, d);
        push_b(1'b0, 8'h2C);
    endtask

    task automatic send_win(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d,
                            input bit good);
        bit ok = 1'b0;
        win_x0 = a;
        win_x1 = b;
        win_y0 = c;
        win_y1 = d;
        win_valid = 1'b1;
        if (good) push_win(a, b, c, d);
        for (int i = 0; i < 50; i++) begin
            if (win_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        win_valid = 1'b0;
        chk("win_accept", 32'(ok), 32'd1);
    endtask

    task automatic send_pix(input logic [15:0] p, input bit with_lo);
        bit ok = 1'b0;
        pix_data = p;
        pix_valid = 1'b1;
        push_b(1'b1, p[15:8]);
        if (with_lo) push_b(1'b1, p[7:0]);
        for (int i = 0; i < 200; i++) begin
            if (pix_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        pix_valid = 1'b0;
        chk("pix_accept", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int lim);
        for (int i = 0; i < lim; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        int base;
        int pbase;
        int idle_cyc;
        bit seen;

        repeat (3) @(negedge clk);
        chk("rst_outs", 32'(outs()), 32'h8000);
        reset_n = 1'b1;
        @(negedge clk);

        // Window request before init must not be taken.
        win_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("win_ready_pre_init", 32'(win_ready), 32'd0);
        chk("busy_pre_init", 32'(busy), 32'd0);
        win_valid = 1'b0;

        // Init script.
        push_b(1'b0, 8'h01);
        push_b(1'b0, 8'h11);
        push_b(1'b0, 8'h3A);
        push_b(1'b1, 8'h05);
        push_b(1'b0, 8'h29);
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        wait_idle("init_idle", 3000);
        chk("init_ok", 32'(init_ok), 32'd1);
        chk("rst_low_len", 32'(rst_len), 32'd8);
        chk("gap_after_swreset", 32'(gap01 >= 8), 32'd1);
        chk("init_sb_empty", 32'(exp_q.size()), 32'd0);

        // Window 2..5 x 10..11 -> 8 pixels.
        pbase = n_pix;
        send_win(8'd2, 8'd5, 8'd10, 8'd11, 1'b1);
        for (int i = 0; i < 8; i++)
            send_pix(16'hA000 + 16'(i * 16'h0111), 1'b1);
        wait_idle("win_idle", 500);
        chk("win_pix_count", 32'(n_pix - pbase), 32'd8);
        pix_valid = 1'b1;
        pix_data = 16'hBEEF;
        repeat (5) @(negedge clk);
        chk("no_9th_pix", 32'(n_pix - pbase), 32'd8);
        chk("no_rdy_after", 32'(pix_ready), 32'd0);
        pix_valid = 1'b0;
        chk("win_sb_empty", 32'(exp_q.size()), 32'd0);

        // Two pixels with a gap between them.
        send_win(8'd0, 8'd0, 8'd0, 8'd1, 1'b1);
        send_pix(16'hF800, 1'b1);
        for (int i = 0; i < 200; i++) begin
            if (pix_ready) break;
            @(negedge clk);
        end
        base = n_loads;
        repeat (5) @(negedge clk);
        chk("gap_no_load", 32'(n_loads - base), 32'd0);
        chk("gap_stall_rdy", 32'(pix_ready), 32'd1);
        send_pix(16'h07E0, 1'b1);
        wait_idle("gap_idle", 200);
        chk("gap_sb_empty", 32'(exp_q.size()), 32'd0);

        // Bad window then a good one.
        base = n_loads;
        send_win(8'd9, 8'd3, 8'd0, 8'd0, 1'b0);
        repeat (3) @(negedge clk);
        chk("bad_err", 32'(err), 32'd1);
        chk("bad_idle", 32'(busy), 32'd0);
        chk("bad_no_load", 32'(n_loads - base), 32'd0);
        send_win(8'd4, 8'd4, 8'd7, 8'd7, 1'b1);
        chk("err_cleared", 32'(err), 32'd0);
        send_pix(16'h1234, 1'b1);
        wait_idle("good_idle", 200);
        chk("good_sb_empty", 32'(exp_q.size()), 32'd0);

        // Abort during the hi byte of the third pixel.
        send_win(8'd1, 8'd4, 8'd1, 8'd4, 1'b1);
        send_pix(16'h1111, 1'b1);
        send_pix(16'h2222, 1'b1);
        send_pix(16'h3333, 1'b0);
        chk("abort_at_hi", 32'(byte_load), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        base = n_loads;
        pbase = n_pix;
        idle_cyc = -1;
        for (int i = 0; i < 50; i++) begin
            if (!busy) begin
                idle_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("abort_idle_next", 32'(idle_cyc - done_cyc), 32'd1);
        pix_data = 16'h4444;
        pix_valid = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (pix_ready) seen = 1'b1;
        end
        pix_valid = 1'b0;
        chk("abort_no_rdy", 32'(seen), 32'd0);
        chk("abort_no_load", 32'(n_loads - base), 32'd0);
        chk("abort_no_pix", 32'(n_pix - pbase), 32'd0);
        chk("abort_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("abort_keeps_init", 32'(init_ok), 32'd1);

        // Async reset while a byte is in flight.
        lat_force = 10;
        base = n_loads;
        send_win(8'd0, 8'd0, 8'd0, 8'd0, 1'b1);
        for (int i = 0; i < 200; i++) begin
            if (n_loads >= base + 3) break;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_outs", 32'(outs()), 32'h8000);
        skip_hold = 1'b1;
        exp_q.delete();
        base = n_loads;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_outs", 32'(outs()), 32'h8000);
        chk("post_rst_no_load", 32'(n_loads - base), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
